// File: rtl/wh_router_port_if.sv
// Link-side and crossbar-side signals of one wormhole router port.
// The router takes the slave view; the link/crossbar environment takes the master view.
interface wh_router_port_if #(
  parameter int FLIT_W    = 32,
  parameter int NUM_PORTS = 4
);
  logic                        in_valid;
  logic [FLIT_W-1:0]           in_flit;
  logic                        credit_out;
  logic [NUM_PORTS-1:0]        port_rqs;
  logic                        xbar_gnt;
  logic [FLIT_W-1:0]           xbar_flit;
  logic [NUM_PORTS-1:0]        req_in;
  logic [NUM_PORTS*FLIT_W-1:0] xbar_flits_in;
  logic [NUM_PORTS-1:0]        gnt_out;
  logic                        credit_in;
  logic                        out_valid;
  logic [FLIT_W-1:0]           out_flit;
  logic [NUM_PORTS-1:0]        xbar_cfg_vector;
  logic                        ovf_err;
  logic                        credit_err;
  logic                        route_err;

  modport slave (
    input  in_valid, in_flit, xbar_gnt, req_in, xbar_flits_in, credit_in,
    output credit_out, port_rqs, xbar_flit, gnt_out, out_valid, out_flit,
           xbar_cfg_vector, ovf_err, credit_err, route_err
  );

  modport master (
    output in_valid, in_flit, xbar_gnt, req_in, xbar_flits_in, credit_in,
    input  credit_out, port_rqs, xbar_flit, gnt_out, out_valid, out_flit,
           xbar_cfg_vector, ovf_err, credit_err, route_err
  );
endinterface

// File: rtl/wh_router_port.sv
// Wormhole router port: input FIFO with head-flit routing and bad-route dropping,
// plus a packet-locked round-robin output arbiter with downstream credit tracking.
//
// rx_state  | RX_ROUTE   | flits route normally; a bad head starts a drop
//           | RX_DROP    | discarding the remainder of a badly routed packet
// arb_state | ARB_OPEN   | no packet owns the output; round-robin scan
//           | ARB_LOCKED | owner_q holds the output until its tail is granted
module wh_router_port #(
  parameter int FLIT_W    = 32,
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int CREDITS   = 4
) (
  input  logic            clk,
  input  logic            rst,
  wh_router_port_if.slave port_if
);
  localparam int PB = $clog2(NUM_PORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [PB:0]   NP_W     = (PB+1)'(NUM_PORTS);
  localparam logic [PB-1:0] LAST     = PB'(NUM_PORTS - 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [1:0]    T_HEAD   = 2'b01;

  typedef enum logic {RX_ROUTE, RX_DROP} rx_state_t;
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop;
  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic              head_is_hd, bad_route, dropping;
  logic [PB:0]       dest_raw;
  logic [PB-1:0]     dest, route_q;
  rx_state_t         rx_state;
  arb_state_t        arb_state;
  logic [PB-1:0]     owner_q, rr_q, gnt_idx, rr_next;
  logic [PB:0]       scan;
  logic              gnt_any;
  logic [FLIT_W-1:0] gnt_flit;
  logic [1:0]        gnt_type;
  logic [CW-1:0]     cnt_q;
  logic              credit_out_q, ovf_q, credit_err_q, route_err_q, out_valid_q;
  logic [FLIT_W-1:0] out_flit_q;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_type  = head[FLIT_W-1 -: 2];
  assign head_is_hd = !empty && head_type[0];
  // The dest field carries one guard bit above PB so out-of-range codes are detectable.
  assign dest_raw   = head[PB:0];
  assign bad_route  = head_is_hd && (dest_raw >= NP_W) && (rx_state == RX_ROUTE);
  assign dropping   = !empty && ((rx_state == RX_DROP) || bad_route);
  assign dest       = head_is_hd ? dest_raw[PB-1:0] : route_q;
  assign pop        = !empty && (dropping || port_if.xbar_gnt);
  assign push       = port_if.in_valid && (!full || pop);

  assign port_if.port_rqs  = (!empty && !dropping) ? (NUM_PORTS'(1) << dest) : '0;
  assign port_if.xbar_flit = empty ? '0 : head;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    if (cnt_q != '0) begin
      if (arb_state == ARB_LOCKED) begin
        gnt_any = port_if.req_in[owner_q];
        gnt_idx = owner_q;
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          scan = {1'b0, rr_q} + (PB+1)'(k);
          if (scan >= NP_W) scan = scan - NP_W;
          if (!gnt_any && port_if.req_in[scan[PB-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[PB-1:0];
          end
        end
      end
    end
  end

  assign gnt_flit = port_if.xbar_flits_in[FLIT_W*int'(gnt_idx) +: FLIT_W];
  assign gnt_type = gnt_flit[FLIT_W-1 -: 2];
  assign rr_next  = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  assign port_if.gnt_out         = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
  assign port_if.xbar_cfg_vector = (arb_state == ARB_LOCKED) ? (NUM_PORTS'(1) << owner_q) : '0;
  assign port_if.credit_out      = credit_out_q;
  assign port_if.out_valid       = out_valid_q;
  assign port_if.out_flit        = out_flit_q;
  assign port_if.ovf_err         = ovf_q;
  assign port_if.credit_err      = credit_err_q;
  assign port_if.route_err       = route_err_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= port_if.in_flit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      route_q      <= '0;
      rx_state     <= RX_ROUTE;
      arb_state    <= ARB_OPEN;
      owner_q      <= '0;
      rr_q         <= '0;
      cnt_q        <= CRED_MAX;
      credit_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      credit_err_q <= 1'b0;
      route_err_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      credit_out_q <= pop;
      if (port_if.in_valid && full && !pop) ovf_q <= 1'b1;

      if (pop) begin
        case (rx_state)
          RX_ROUTE: begin
            if (bad_route) begin
              route_err_q <= 1'b1;
              if (!head_type[1]) rx_state <= RX_DROP;
            end else if (head_type[0]) begin
              route_q <= dest;
            end
          end
          RX_DROP: if (head_type[1]) rx_state <= RX_ROUTE;
          default: rx_state <= RX_ROUTE;
        endcase
      end

      if (gnt_any) begin
        if (gnt_type == T_HEAD) begin
          arb_state <= ARB_LOCKED;
          owner_q   <= gnt_idx;
        end else if (gnt_type[1]) begin
          arb_state <= ARB_OPEN;
          rr_q      <= rr_next;
        end
        out_flit_q <= gnt_flit;
      end
      out_valid_q <= gnt_any;

      if (port_if.credit_in && (cnt_q == CRED_MAX)) credit_err_q <= 1'b1;
      if (gnt_any && !port_if.credit_in)
        cnt_q <= cnt_q - 1'b1;
      else if (!gnt_any && port_if.credit_in && (cnt_q != CRED_MAX))
        cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_wh_router_port.sv
// Self-checking bench for wh_router_port against a queue-based reference model.
module tb_wh_router_port;
  localparam int FW = 32, NP = 4, DP = 4, CR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wh_router_port_if #(.FLIT_W(FW), .NUM_PORTS(NP)) bus ();
  wh_router_port #(.FLIT_W(FW), .NUM_PORTS(NP), .DEPTH(DP), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .port_if(bus));

  int nvec = 0, nerr = 0;

  // reference model state
  logic [FW-1:0] mq[$];
  logic [1:0]    m_route;
  bit            m_drop, m_cout, m_ovf, m_rerr, m_cerr, m_lock, m_ov;
  int            m_owner, m_rr, m_cnt;
  logic [FW-1:0] m_of;
  // model predictions for the current inputs
  logic [NP-1:0] e_rqs, e_gnt, e_cfg;
  logic [FW-1:0] e_xflit;
  logic [1:0]    e_dest;
  bit            e_ishd, e_bad, e_dropping, e_pop;
  int            e_g;

  function automatic logic [FW-1:0] slice_of(int g);
    return bus.xbar_flits_in[g*FW +: FW];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_route = 0; m_drop = 0; m_cout = 0; m_ovf = 0; m_rerr = 0; m_cerr = 0;
    m_lock = 0; m_owner = 0; m_rr = 0; m_cnt = CR; m_ov = 0; m_of = '0;
  endtask

  task automatic model_comb();
    logic [FW-1:0] h;
    logic [2:0] raw;
    bit empty;
    empty = (mq.size() == 0);
    h = empty ? '0 : mq[0];
    raw = h[2:0];
    e_xflit = h;
    e_ishd = !empty && (h[31:30] == 2'b01 || h[31:30] == 2'b11);
    e_bad = e_ishd && (raw >= 3'd4) && !m_drop;
    e_dropping = !empty && (m_drop || e_bad);
    e_dest = e_ishd ? raw[1:0] : m_route;
    e_rqs = (!empty && !e_dropping) ? (4'b0001 << e_dest) : 4'b0000;
    e_pop = !empty && (e_dropping || bus.xbar_gnt);
    e_g = -1;
    if (m_cnt > 0) begin
      if (m_lock) begin
        if (bus.req_in[m_owner]) e_g = m_owner;
      end else begin
        for (int k = 0; k < NP; k++)
          if (e_g < 0 && bus.req_in[(m_rr + k) % NP]) e_g = (m_rr + k) % NP;
      end
    end
    e_gnt = (e_g >= 0) ? (4'b0001 << e_g) : 4'b0000;
    e_cfg = m_lock ? (4'b0001 << m_owner) : 4'b0000;
  endtask

  task automatic model_clock();
    logic [FW-1:0] f, s;
    bit was_full;
    was_full = (mq.size() == DP);
    m_cout = e_pop;
    if (e_pop) begin
      f = mq.pop_front();
      if (m_drop) begin
        if (f[31]) m_drop = 0;
      end else if (e_bad) begin
        m_rerr = 1;
        if (f[31:30] == 2'b01) m_drop = 1;
      end else if (f[30]) begin
        m_route = f[1:0];
      end
    end
    if (bus.in_valid) begin
      if (!was_full || e_pop) mq.push_back(bus.in_flit);
      else m_ovf = 1;
    end
    if (e_g >= 0) begin
      s = slice_of(e_g);
      if (s[31:30] == 2'b01) begin
        m_lock = 1; m_owner = e_g;
      end else if (s[31]) begin
        m_lock = 0; m_rr = (e_g + 1) % NP;
      end
      m_ov = 1; m_of = s;
    end else begin
      m_ov = 0;
    end
    if (bus.credit_in && m_cnt == CR) m_cerr = 1;
    if (e_g >= 0 && !bus.credit_in) m_cnt--;
    else if (e_g < 0 && bus.credit_in && m_cnt < CR) m_cnt++;
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (!rst) model_reset(); else model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_flit = '0; bus.xbar_gnt = 0;
    bus.req_in = '0; bus.xbar_flits_in = '0; bus.credit_in = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
    nvec++; if ({bus.credit_out, bus.out_valid, bus.ovf_err, bus.credit_err, bus.route_err} !== 5'b0) begin
      nerr++; $display("FAIL reset_flags: got %b want 00000", {bus.credit_out, bus.out_valid, bus.ovf_err, bus.credit_err, bus.route_err}); end
    nvec++; if ({bus.port_rqs, bus.gnt_out, bus.xbar_cfg_vector} !== 12'h0) begin
      nerr++; $display("FAIL reset_vectors: got %h want 000", {bus.port_rqs, bus.gnt_out, bus.xbar_cfg_vector}); end
    nvec++; if ({bus.xbar_flit, bus.out_flit} !== 64'h0) begin
      nerr++; $display("FAIL reset_data: got %h want 0", {bus.xbar_flit, bus.out_flit}); end
  endtask

  task automatic test_single_flit();
    idle();
    bus.in_valid = 1; bus.in_flit = 32'hC0000002;
    #1; model_comb();
    nvec++; if (bus.port_rqs !== e_rqs) begin
      nerr++; $display("FAIL single_not_visible: got %b want %b", bus.port_rqs, e_rqs); end
    tick();
    bus.in_valid = 0;
    #1; model_comb();
    nvec++; if (bus.port_rqs !== 4'b0100) begin
      nerr++; $display("FAIL single_rqs: got %b want 0100", bus.port_rqs); end
    nvec++; if (bus.xbar_flit !== 32'hC0000002) begin
      nerr++; $display("FAIL single_xbar_flit: got %h want c0000002", bus.xbar_flit); end
    bus.xbar_gnt = (e_rqs != 0);
    tick();
    bus.xbar_gnt = 0;
    #1;
    nvec++; if (bus.credit_out !== 1'b1) begin
      nerr++; $display("FAIL single_credit_pulse: got %b want 1", bus.credit_out); end
    tick();
    #1;
    nvec++; if (bus.credit_out !== 1'b0) begin
      nerr++; $display("FAIL single_credit_end: got %b want 0", bus.credit_out); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] pkt[5];
    logic [1:0] d;
    d = 2'($urandom_range(0, 3));
    for (int i = 0; i < 5; i++) pkt[i] = $urandom;
    pkt[0][31:30] = 2'b01; pkt[0][2] = 1'b0; pkt[0][1:0] = d;
    pkt[1][31:30] = 2'b00; pkt[2][31:30] = 2'b00;
    pkt[3][31:30] = 2'b10; pkt[4][31:30] = 2'b00;
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_flit = pkt[i];
      #1; model_comb();
      nvec++; if (bus.ovf_err !== m_ovf) begin
        nerr++; $display("FAIL ovf_progress[%0d]: got %b want %b", i, bus.ovf_err, m_ovf); end
      tick();
    end
    bus.in_valid = 0;
    #1;
    nvec++; if (bus.ovf_err !== 1'b1) begin
      nerr++; $display("FAIL ovf_set: got %b want 1", bus.ovf_err); end
    for (int i = 0; i < 4; i++) begin
      bus.xbar_gnt = 1;
      #1; model_comb();
      nvec++; if (bus.xbar_flit !== pkt[i]) begin
        nerr++; $display("FAIL ovf_drain_flit[%0d]: got %h want %h", i, bus.xbar_flit, pkt[i]); end
      nvec++; if (bus.port_rqs !== (4'b0001 << d)) begin
        nerr++; $display("FAIL ovf_drain_route[%0d]: got %b want %b", i, bus.port_rqs, 4'b0001 << d); end
      tick();
      bus.xbar_gnt = 0;
      #1;
      nvec++; if (bus.credit_out !== 1'b1) begin
        nerr++; $display("FAIL ovf_drain_credit[%0d]: got %b want 1", i, bus.credit_out); end
    end
    #1;
    nvec++; if (bus.port_rqs !== 4'b0000) begin
      nerr++; $display("FAIL ovf_drained_empty: got %b want 0000", bus.port_rqs); end
  endtask

  task automatic test_arbitration();
    int pos[NP];
    int order[$];
    logic [FW-1:0] f;
    idle();
    for (int i = 0; i < NP; i++) pos[i] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        bus.req_in[i] = (pos[i] < 3);
        f = $urandom;
        f[31:30] = (pos[i] == 0) ? 2'b01 : (pos[i] == 1) ? 2'b00 : 2'b10;
        bus.xbar_flits_in[i*FW +: FW] = f;
      end
      bus.credit_in = m_ov;
      #1; model_comb();
      nvec++; if (bus.gnt_out !== e_gnt) begin
        nerr++; $display("FAIL arb_gnt[%0d]: got %b want %b", cyc, bus.gnt_out, e_gnt); end
      nvec++; if (bus.xbar_cfg_vector !== e_cfg) begin
        nerr++; $display("FAIL arb_cfg[%0d]: got %b want %b", cyc, bus.xbar_cfg_vector, e_cfg); end
      nvec++; if ({bus.out_valid, bus.out_flit} !== {m_ov, m_of}) begin
        nerr++; $display("FAIL arb_out[%0d]: got %b/%h want %b/%h", cyc, bus.out_valid, bus.out_flit, m_ov, m_of); end
      if (e_g >= 0) begin
        if (pos[e_g] == 0) order.push_back(e_g);
        pos[e_g]++;
      end
      tick();
    end
    nvec++; if (order.size() != NP) begin
      nerr++; $display("FAIL arb_packets: got %0d want %0d", order.size(), NP); end
    for (int k = 0; k < order.size(); k++) begin
      nvec++; if (order[k] != k) begin
        nerr++; $display("FAIL arb_order[%0d]: got %0d want %0d", k, order[k], k); end
    end
    idle();
  endtask

  task automatic test_credits();
    int ngr;
    ngr = 0;
    idle();
    bus.req_in = 4'b0001;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.xbar_flits_in[FW-1:0] = {2'b00, 30'($urandom)};
      bus.credit_in = (cyc == 5);
      #1; model_comb();
      nvec++; if (bus.gnt_out !== e_gnt) begin
        nerr++; $display("FAIL cred_gnt[%0d]: got %b want %b", cyc, bus.gnt_out, e_gnt); end
      nvec++; if (bus.out_valid !== m_ov) begin
        nerr++; $display("FAIL cred_out_valid[%0d]: got %b want %b", cyc, bus.out_valid, m_ov); end
      if (cyc == 6) begin
        nvec++; if (bus.gnt_out !== 4'b0001) begin
          nerr++; $display("FAIL cred_regrant: got %b want 0001", bus.gnt_out); end
      end
      if (bus.gnt_out[0]) ngr++;
      tick();
    end
    nvec++; if (ngr != CR + 1) begin
      nerr++; $display("FAIL cred_total_grants: got %0d want %0d", ngr, CR + 1); end
    idle();
    bus.credit_in = 1;
    for (int i = 0; i < CR; i++) tick();
    bus.credit_in = 0;
    #1;
    nvec++; if (bus.credit_err !== 1'b0) begin
      nerr++; $display("FAIL cred_no_err: got %b want 0", bus.credit_err); end
  endtask

  task automatic test_bad_route();
    logic [FW-1:0] bf[3];
    int nc;
    nc = 0;
    bf[0] = 32'h40000005;
    bf[1] = {2'b00, 30'($urandom)};
    bf[2] = {2'b10, 30'($urandom)};
    idle();
    for (int cyc = 0; cyc < 7; cyc++) begin
      bus.in_valid = (cyc < 3);
      bus.in_flit = (cyc < 3) ? bf[cyc] : '0;
      #1; model_comb();
      nvec++; if (bus.port_rqs !== 4'b0000) begin
        nerr++; $display("FAIL bad_rqs[%0d]: got %b want 0000", cyc, bus.port_rqs); end
      nvec++; if (bus.credit_out !== m_cout) begin
        nerr++; $display("FAIL bad_credit[%0d]: got %b want %b", cyc, bus.credit_out, m_cout); end
      if (bus.credit_out) nc++;
      tick();
    end
    nvec++; if (nc != 3) begin
      nerr++; $display("FAIL bad_credit_count: got %0d want 3", nc); end
    nvec++; if (bus.route_err !== 1'b1) begin
      nerr++; $display("FAIL bad_route_err: got %b want 1", bus.route_err); end
    bus.in_valid = 1; bus.in_flit = 32'hC0000001;
    tick();
    bus.in_valid = 0;
    #1; model_comb();
    nvec++; if (bus.port_rqs !== 4'b0010) begin
      nerr++; $display("FAIL bad_recover_rqs: got %b want 0010", bus.port_rqs); end
    bus.xbar_gnt = 1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid_packet();
    int ngr;
    idle();
    bus.req_in = 4'b0010;
    bus.xbar_flits_in[FW +: FW] = 32'h40000011;
    #1; model_comb();
    nvec++; if (bus.gnt_out !== 4'b0010) begin
      nerr++; $display("FAIL mid_head_gnt: got %b want 0010", bus.gnt_out); end
    tick();
    bus.xbar_flits_in[FW +: FW] = 32'h00000012;
    bus.in_valid = 1; bus.in_flit = 32'h40000001;
    #1;
    nvec++; if (bus.xbar_cfg_vector !== 4'b0010) begin
      nerr++; $display("FAIL mid_locked: got %b want 0010", bus.xbar_cfg_vector); end
    tick();
    idle();
    rst = 0;
    tick();
    rst = 1;
    #1;
    nvec++; if ({bus.xbar_cfg_vector, bus.port_rqs, bus.gnt_out} !== 12'h0) begin
      nerr++; $display("FAIL mid_reset_vectors: got %h want 000", {bus.xbar_cfg_vector, bus.port_rqs, bus.gnt_out}); end
    nvec++; if ({bus.out_valid, bus.credit_out, bus.ovf_err, bus.credit_err, bus.route_err} !== 5'b0) begin
      nerr++; $display("FAIL mid_reset_flags: got %b want 00000", {bus.out_valid, bus.credit_out, bus.ovf_err, bus.credit_err, bus.route_err}); end
    nvec++; if ({bus.out_flit, bus.xbar_flit} !== 64'h0) begin
      nerr++; $display("FAIL mid_reset_data: got %h want 0", {bus.out_flit, bus.xbar_flit}); end
    ngr = 0;
    bus.req_in = 4'b1111;
    for (int cyc = 0; cyc < 5; cyc++) begin
      for (int i = 0; i < NP; i++)
        bus.xbar_flits_in[i*FW +: FW] = (i == 0 && cyc > 0) ? {2'b00, 30'($urandom)} : {2'b01, 30'($urandom)};
      #1; model_comb();
      nvec++; if (bus.gnt_out !== e_gnt) begin
        nerr++; $display("FAIL mid_gnt[%0d]: got %b want %b", cyc, bus.gnt_out, e_gnt); end
      if (cyc == 0) begin
        nvec++; if (bus.gnt_out !== 4'b0001) begin
          nerr++; $display("FAIL mid_restart_from_0: got %b want 0001", bus.gnt_out); end
      end
      if (bus.gnt_out != 0) ngr++;
      tick();
    end
    nvec++; if (ngr != CR) begin
      nerr++; $display("FAIL mid_full_credits: got %0d want %0d", ngr, CR); end
    idle();
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    idle();
    rst = 0; tick(); rst = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[2] = 1'b0;
      bus.in_valid = $urandom_range(0, 1);
      bus.in_flit = f;
      bus.xbar_gnt = $urandom_range(0, 1);
      bus.req_in = 4'($urandom);
      for (int i = 0; i < NP; i++) bus.xbar_flits_in[i*FW +: FW] = $urandom;
      bus.credit_in = ($urandom_range(0, 9) < 3);
      #1; model_comb();
      nvec++; if (bus.port_rqs !== e_rqs) begin
        nerr++; $display("FAIL rnd_rqs[%0d]: got %b want %b", cyc, bus.port_rqs, e_rqs); end
      nvec++; if (bus.xbar_flit !== e_xflit) begin
        nerr++; $display("FAIL rnd_xbar_flit[%0d]: got %h want %h", cyc, bus.xbar_flit, e_xflit); end
      nvec++; if (bus.gnt_out !== e_gnt) begin
        nerr++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, bus.gnt_out, e_gnt); end
      nvec++; if (bus.xbar_cfg_vector !== e_cfg) begin
        nerr++; $display("FAIL rnd_cfg[%0d]: got %b want %b", cyc, bus.xbar_cfg_vector, e_cfg); end
      nvec++; if ({bus.credit_out, bus.out_valid, bus.out_flit} !== {m_cout, m_ov, m_of}) begin
        nerr++; $display("FAIL rnd_regs[%0d]: got %b%b/%h want %b%b/%h", cyc, bus.credit_out, bus.out_valid, bus.out_flit, m_cout, m_ov, m_of); end
      nvec++; if ({bus.ovf_err, bus.credit_err, bus.route_err} !== {m_ovf, m_cerr, m_rerr}) begin
        nerr++; $display("FAIL rnd_errs[%0d]: got %b want %b", cyc, {bus.ovf_err, bus.credit_err, bus.route_err}, {m_ovf, m_cerr, m_rerr}); end
      tick();
    end
    idle();
  endtask

  task automatic test_credit_err();
    idle();
    rst = 0; tick(); rst = 1;
    bus.credit_in = 1;
    tick();
    bus.credit_in = 0;
    #1;
    nvec++; if (bus.credit_err !== 1'b1) begin
      nerr++; $display("FAIL credit_err_set: got %b want 1", bus.credit_err); end
    bus.req_in = 4'b0100;
    bus.xbar_flits_in[2*FW +: FW] = 32'h80000000;
    #1;
    nvec++; if (bus.gnt_out !== 4'b0100) begin
      nerr++; $display("FAIL credit_saturated_gnt: got %b want 0100", bus.gnt_out); end
    tick();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_single_flit();
    test_overflow();
    test_arbitration();
    test_credits();
    test_bad_route();
    test_reset_mid_packet();
    test_random();
    test_credit_err();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
